// File: rtl/reg_wr_sched.sv
// reg_wr_sched: two-requester register-file write arbiter with a pending-write scoreboard; define RWS_BYPASS_EN to add write-port forwarding
module reg_wr_sched #(
   parameter int DATA_W = 16,
   parameter int NREG = 8,
   localparam int AW = $clog2(NREG)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0,
   input  logic              req1,
   input  logic [AW-1:0]     dr0,
   input  logic [AW-1:0]     dr1,
   input  logic [DATA_W-1:0] data0,
   input  logic [DATA_W-1:0] data1,
   output logic              gnt0,
   output logic              gnt1,
   input  logic              issue_valid,
   input  logic [AW-1:0]     issue_dr,
   input  logic [AW-1:0]     sr1,
   input  logic [AW-1:0]     sr2,
`ifdef RWS_BYPASS_EN
   output logic              fwd1_hit,
   output logic              fwd2_hit,
   output logic [DATA_W-1:0] fwd_data,
`endif
   output logic              stall,
   output logic              rf_en,
   output logic [AW-1:0]     rf_dr,
   output logic [DATA_W-1:0] rf_data
);
   logic            r_rr_ptr;
   logic [NREG-1:0] r_pending;
   logic [NREG-1:0] w_set;
   logic [NREG-1:0] w_clr;
   logic            w_grant;
   logic            w_src1;
   logic            w_src2;

   // grants: a lone request wins at once, a collision goes to r_rr_ptr; nothing is granted during reset
   always_comb begin
      gnt0    = !rst && req0 && (!req1 || !r_rr_ptr);
      gnt1    = !rst && req1 && (!req0 || r_rr_ptr);
      w_grant = gnt0 | gnt1;
      w_set   = issue_valid ? (NREG'(1) << issue_dr) : '0;
      w_clr   = rf_en ? (NREG'(1) << rf_dr) : '0;
`ifdef RWS_BYPASS_EN
      fwd1_hit = rf_en && (sr1 == rf_dr);
      fwd2_hit = rf_en && (sr2 == rf_dr);
      fwd_data = rf_data;
      w_src1   = r_pending[sr1] && !fwd1_hit;
      w_src2   = r_pending[sr2] && !fwd2_hit;
`else
      w_src1   = r_pending[sr1];
      w_src2   = r_pending[sr2];
`endif
      stall = w_src1 | w_src2;
   end

   // round-robin pointer flips only when both requesters collided
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_rr_ptr <= 1'b0;
      else if (req0 && req1) r_rr_ptr <= ~r_rr_ptr;
   end

   // scoreboard: clear on write-back, set on issue; set applied last so it wins
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_pending <= '0;
      else r_pending <= (r_pending & ~w_clr) | w_set;
   end

   // register-file write stage, one cycle after the grant; dr/data hold when idle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rf_en   <= 1'b0;
         rf_dr   <= '0;
         rf_data <= '0;
      end else begin
         rf_en <= w_grant;
         if (w_grant) begin
            rf_dr   <= gnt0 ? dr0 : dr1;
            rf_data <= gnt0 ? data0 : data1;
         end
      end
   end
endmodule

// File: tb/tb_reg_wr_sched.sv
// tb_reg_wr_sched: randomized and directed checks of reg_wr_sched against a behavioural model
module tb_reg_wr_sched;
   localparam int DW = 16;
   localparam int NR = 8;
   localparam int AW = 3;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          req0 = 1'b0, req1 = 1'b0;
   logic [AW-1:0] dr0 = '0, dr1 = '0;
   logic [DW-1:0] data0 = '0, data1 = '0;
   logic          gnt0, gnt1;
   logic          issue_valid = 1'b0;
   logic [AW-1:0] issue_dr = '0, sr1 = '0, sr2 = '0;
   logic          stall, rf_en;
   logic [AW-1:0] rf_dr;
   logic [DW-1:0] rf_data;
`ifdef RWS_BYPASS_EN
   logic          fwd1_hit, fwd2_hit;
   logic [DW-1:0] fwd_data;
`endif

   reg_wr_sched #(.DATA_W(DW), .NREG(NR)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .req1(req1), .dr0(dr0), .dr1(dr1), .data0(data0), .data1(data1),
      .gnt0(gnt0), .gnt1(gnt1),
      .issue_valid(issue_valid), .issue_dr(issue_dr), .sr1(sr1), .sr2(sr2),
`ifdef RWS_BYPASS_EN
      .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit), .fwd_data(fwd_data),
`endif
      .stall(stall), .rf_en(rf_en), .rf_dr(rf_dr), .rf_data(rf_data)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   // reference state: which registers await a write, who wins the next collision, and the write port
   bit m_pend [NR];
   bit m_fav;
   bit m_en;
   int m_dr;
   int m_data;
   bit e_g0, e_g1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      foreach (m_pend[i]) m_pend[i] = 0;
      m_fav = 0;
      m_en = 0;
      m_dr = 0;
      m_data = 0;
   endtask

   function automatic bit src_wait(input int sr);
      bit w = m_pend[sr];
`ifdef RWS_BYPASS_EN
      if (m_en && sr == m_dr) w = 0;
`endif
      return w;
   endfunction

   // one clock: called just after a falling edge with inputs settled, returns at the next falling edge
   task automatic step(input string tag);
      if (req0 && req1) begin
         e_g0 = !m_fav;
         e_g1 = m_fav;
      end else begin
         e_g0 = req0;
         e_g1 = req1;
      end
      #1;
      check({tag, "_gnt0"}, gnt0, e_g0);
      check({tag, "_gnt1"}, gnt1, e_g1);
      check({tag, "_stall"}, stall, src_wait(int'(sr1)) | src_wait(int'(sr2)));
      check({tag, "_rf_en"}, rf_en, m_en);
      check({tag, "_rf_dr"}, rf_dr, m_dr);
      check({tag, "_rf_data"}, rf_data, m_data);
`ifdef RWS_BYPASS_EN
      check({tag, "_fwd1"}, fwd1_hit, m_en && int'(sr1) == m_dr);
      check({tag, "_fwd2"}, fwd2_hit, m_en && int'(sr2) == m_dr);
      check({tag, "_fwd_data"}, fwd_data, m_data);
`endif
      @(posedge clk);
      if (m_en) m_pend[m_dr] = 0;
      if (issue_valid) m_pend[issue_dr] = 1;
      if (req0 && req1) m_fav = !m_fav;
      m_en = e_g0 | e_g1;
      if (m_en) begin
         m_dr = e_g0 ? int'(dr0) : int'(dr1);
         m_data = e_g0 ? int'(data0) : int'(data1);
      end
      @(negedge clk);
      if (e_g0) req0 = 1'b0;
      if (e_g1) req1 = 1'b0;
   endtask

   task automatic idle();
      req0 = 1'b0;
      req1 = 1'b0;
      issue_valid = 1'b0;
      sr1 = '0;
      sr2 = '0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      model_reset();
      @(negedge clk);
      rst = 1'b0;
   endtask

   // new requests only from idle requesters, so pending ones stay stable until granted
   task automatic rand_in();
      if (!req0 && $urandom_range(1, 0) == 1) begin
         req0 = 1'b1;
         dr0 = AW'($urandom_range(NR - 1, 0));
         data0 = DW'($urandom);
      end
      if (!req1 && $urandom_range(1, 0) == 1) begin
         req1 = 1'b1;
         dr1 = AW'($urandom_range(NR - 1, 0));
         data1 = DW'($urandom);
      end
      issue_valid = ($urandom_range(2, 0) == 0);
      issue_dr = AW'($urandom_range(NR - 1, 0));
      sr1 = AW'($urandom_range(NR - 1, 0));
      sr2 = AW'($urandom_range(NR - 1, 0));
   endtask

   initial begin
      req0 = 1'b1;
      #12;
      check("rst_gnt0", gnt0, 0);
      check("rst_rf_en", rf_en, 0);
      check("rst_rf_dr", rf_dr, 0);
      check("rst_rf_data", rf_data, 0);
      check("rst_stall", stall, 0);
      model_reset();
      idle();
      @(negedge clk);
      rst = 1'b0;

      // single write from requester 0
      req0 = 1'b1; dr0 = 3'd3; data0 = 16'h1234;
      #1 check("d033_gnt0", gnt0, 1);
      step("d033a");
      check("d033_en", rf_en, 1);
      check("d033_dr", rf_dr, 3);
      check("d033_data", rf_data, 16'h1234);
      step("d033b");

      // both requesters held high from reset alternate, requester 0 first
      do_reset();
      dr0 = 3'd1; dr1 = 3'd2; data0 = 16'h0101; data1 = 16'h0202;
      for (int i = 0; i < 6; i++) begin
         req0 = 1'b1;
         req1 = 1'b1;
         #1 check("d034_alt", gnt0, (i % 2 == 0));
         step("d034");
         check("d034_rfdr", rf_dr, (i % 2 == 0) ? 1 : 2);
      end
      idle();
      step("d034z");

      // stall on a pending source until its write lands
      do_reset();
      issue_valid = 1'b1; issue_dr = 3'd5; sr1 = 3'd5;
      step("d035a");
      issue_valid = 1'b0;
      #1 check("d035_pend", stall, 1);
      req1 = 1'b1; dr1 = 3'd5; data1 = 16'h5555;
      step("d035b");
`ifdef RWS_BYPASS_EN
      #1 check("d035_wr", stall, 0);
`else
      #1 check("d035_wr", stall, 1);
`endif
      step("d035c");
      #1 check("d035_done", stall, 0);
      step("d035d");

      // re-issue in the same cycle as the write-back keeps the register pending
      sr1 = 3'd0;
      issue_valid = 1'b1; issue_dr = 3'd4;
      step("d036a");
      issue_valid = 1'b0;
      req0 = 1'b1; dr0 = 3'd4; data0 = 16'h4444;
      step("d036b");
      issue_valid = 1'b1; issue_dr = 3'd4; sr2 = 3'd4;
      step("d036c");
      issue_valid = 1'b0;
      #1 check("d036_keep", stall, 1);
      step("d036d");

      for (int i = 0; i < 400; i++) begin
         rand_in();
         step("rnd");
      end

      // reset in the middle of a cycle while requester 1 holds the grant
      idle();
      step("d037a");
      req0 = 1'b1; req1 = 1'b1; dr0 = 3'd2; dr1 = 3'd7; data0 = 16'h2222; data1 = 16'h7777;
      if (!m_fav) begin
         step("d037b");
         req0 = 1'b1;
      end
      #1 check("d037_gnt1", gnt1, 1);
      #2 rst = 1'b1;
      #1;
      check("d037_en", rf_en, 0);
      check("d037_g1", gnt1, 0);
      check("d037_stall", stall, 0);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      #1 check("d037_first", gnt0, 1);
      step("d037c");
      req0 = 1'b1;
      step("d037d");
      idle();
      step("d037e");

      // forwarding of a write-back to a pending source
      issue_valid = 1'b1; issue_dr = 3'd6;
      step("d038a");
      issue_valid = 1'b0;
      req0 = 1'b1; dr0 = 3'd6; data0 = 16'hBEEF;
      step("d038b");
      sr1 = 3'd6;
`ifdef RWS_BYPASS_EN
      #1;
      check("d038_stall", stall, 0);
      check("d038_hit", fwd1_hit, 1);
      check("d038_data", fwd_data, 16'hBEEF);
`else
      #1 check("d038_stall", stall, 1);
`endif
      step("d038c");

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
